// File: rtl/scalar_result_packer.sv
// Packs a serial stream of MAC scalar results into Ndata-wide vectors, LSB slot first.
// Valid/ready on both sides; in_last closes a short vector early.
module scalar_result_packer #(
  parameter int Nbits = 4,
  parameter int Ndata = 3,
  localparam int W  = 2 * Nbits,
  localparam int CW = $clog2(Ndata + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [Ndata*W-1:0] out_vec,
  output logic [CW-1:0]      out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  // state | meaning
  // FILL  | accepting elements into slot cnt, output not valid
  // FULL  | vector presented and held until out_ready, input passes out_ready through
  typedef enum logic {FILL, FULL} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [Ndata*W-1:0] vec_r;
  logic               in_hs;
  logic               out_hs;

  assign in_ready = (state == FILL) | out_ready;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;
  assign out_vec  = vec_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      cnt       <= '0;
      vec_r     <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_hs) begin
            for (int k = 0; k < Ndata; k++) begin
              if (cnt == CW'(k)) vec_r[k*W +: W] <= in_data;
            end
            if (in_last || cnt == CW'(Ndata - 1)) begin
              state     <= FULL;
              out_valid <= 1'b1;
              out_count <= cnt + CW'(1);
              cnt       <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FULL: begin
          if (out_hs) begin
            if (in_hs) begin
              // Element accepted in the draining cycle starts the next vector in slot 0.
              vec_r          <= '0;
              vec_r[W-1:0]   <= in_data;
              if (in_last) begin
                out_count <= CW'(1);
                cnt       <= '0;
              end else begin
                state     <= FILL;
                out_valid <= 1'b0;
                out_count <= '0;
                cnt       <= CW'(1);
              end
            end else begin
              state     <= FILL;
              out_valid <= 1'b0;
              out_count <= '0;
              vec_r     <= '0;
              cnt       <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_result_packer.sv
// Scoreboard bench for scalar_result_packer (Nbits=4, Ndata=3): model packs accepted
// elements into expected vectors, monitor pops and compares on each output handshake.
module tb_scalar_result_packer;
  localparam int NB = 4;
  localparam int ND = 3;
  localparam int W  = 2 * NB;
  localparam int VW = ND * W;
  localparam int CW = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [VW-1:0] out_vec;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [VW-1:0] macc;
  int mcnt;

  scalar_result_packer #(.Nbits(NB), .Ndata(ND)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_vec(out_vec), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic last);
    macc[mcnt*W +: W] = d;
    mcnt++;
    if (mcnt == ND || last) begin
      sb.push_back(32'({CW'(mcnt), macc}));
      macc = '0;
      mcnt = 0;
    end
  endtask

  // Offer one element; returns the number of cycles spent waiting for in_ready.
  task automatic send(input logic [W-1:0] d, input logic last, output int waits);
    in_data = d; in_valid = 1'b1; in_last = last; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_accept", 32'(in_ready), 32'd1);
    else model_accept(d, last);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
        else chk("out_vec_count", 32'({out_count, out_vec}), sb.pop_front());
      end
    end
  end

  initial begin
    int w, tot;
    reset = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    macc = '0; mcnt = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vec", 32'(out_vec), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // basic fill
    out_ready = 1'b1;
    send(8'h11, 0, w); send(8'h22, 0, w); send(8'h33, 0, w);
    in_last = 1'b1;  // in_last without in_valid must be ignored
    @(negedge clk);
    @(negedge clk);
    chk("valid_one_cycle", 32'(out_valid), 32'd0);
    chk("stray_last_vec", 32'(out_vec), 32'd0);
    @(posedge clk); #1;
    in_last = 1'b0;

    // back-pressure
    out_ready = 1'b0;
    send(8'h01, 0, w); send(8'h02, 0, w); send(8'h03, 0, w);
    in_data = 8'h04; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_vec", 32'(out_vec), 32'h030201);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h04, 0, w);
    chk("bp_accept_wait", 32'(w), 32'd0);
    send(8'h05, 0, w); send(8'h06, 0, w);

    // early last, then full vector with no residue
    send(8'hAA, 0, w); send(8'hBB, 1, w);
    send(8'h01, 0, w); send(8'h02, 0, w); send(8'h03, 0, w);

    // simultaneous drain and accept
    tot = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h10 + i), 0, w);
      tot += w;
    end
    chk("stream_no_bubble", 32'(tot), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // reset mid-fill
    send(8'h55, 0, w); send(8'h66, 0, w);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_vec", 32'(out_vec), 32'd0);
    chk("rst_mid_count", 32'(out_count), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    macc = '0; mcnt = 0;
    in_data = 8'hEE; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_vec", 32'(out_vec), 32'd0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    send(8'h07, 0, w); send(8'h08, 0, w); send(8'h09, 0, w);

    // single-element last accepted while FULL drains
    send(8'h21, 0, w); send(8'h22, 0, w); send(8'h23, 0, w);
    send(8'h7F, 1, w);
    chk("last_in_full_wait", 32'(w), 32'd0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule
